lzw_string_unwind: RTL and testbench
====================================

LZW_STRING_UNWIND -- requirements
Module: lzw_string_unwind

Interface
REQ-001 Parameter CODE_W, default 13, dictionary code width.
REQ-002 Parameter CHAR_W, default 8, character width.
REQ-003 Parameter STACK_DEPTH, default 4096, LIFO entries (power of 2).
REQ-004 Port clk  input  1  sole clock, all state on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port code_valid  input  1  input code offered.
REQ-007 Port code  input  CODE_W  code to expand.
REQ-008 Port code_ready  output  1  block accepts code this cycle.
REQ-009 Port dict_en  output  1  dictionary read enable.
REQ-010 Port dict_addr  output  CODE_W  dictionary read address.
REQ-011 Port dict_prefix  input  CODE_W  prefix code of the entry, valid one cycle after dict_en.
REQ-012 Port dict_char  input  CHAR_W  append char of the entry, valid one cycle after dict_en.
REQ-013 Port byte_valid  output  1  output byte offered.
REQ-014 Port byte_data  output  CHAR_W  output byte, first-to-last string order.
REQ-015 Port byte_last  output  1  final byte of current string.
REQ-016 Port byte_ready  input  1  sink accepts byte.
REQ-017 Port root_char  output  CHAR_W  first char of the last expanded string, held until next ROOT.
REQ-018 Port err_overflow  output  1  sticky LIFO overflow flag.

Function
REQ-019 FSM states: IDLE, LOOKUP, WAIT, ROOT, EMIT; one push or pop per cycle max.
REQ-020 code_ready SHALL be 1 only in IDLE; a transfer is code_valid && code_ready.
REQ-021 IDLE on transfer: cur <= code; code < 256 -> ROOT, else -> LOOKUP.
REQ-022 LOOKUP: dict_en=1, dict_addr=cur for exactly one cycle, -> WAIT; dict_en=0 in all other states.
REQ-023 WAIT: push dict_char; dict_prefix < 256 -> ROOT with cur <= dict_prefix, else -> LOOKUP with cur <= dict_prefix.
REQ-024 ROOT: push cur[CHAR_W-1:0], root_char <= cur[CHAR_W-1:0], -> EMIT.
REQ-025 EMIT: byte_valid=1, byte_data=stack top, byte_last=(count==1); pop on byte_ready; pop of last entry -> IDLE.
REQ-026 Latency: string of length L accepted in cycle 0 -> first byte_valid in cycle 2L (literal: cycle 2).
REQ-027 byte_data and byte_last SHALL stay stable while byte_valid && !byte_ready.
REQ-028 Push when count==STACK_DEPTH: set err_overflow, flush LIFO (count<=0), -> IDLE, emit no bytes of that string.
REQ-029 err_overflow clears only on reset; later codes process normally.
REQ-030 No new code accepted until the final byte of the current string is popped.

Reset
REQ-031 rst_n low, any state: state<=IDLE, count<=0, cur<=0, root_char<=0, err_overflow<=0 immediately.
REQ-032 During reset outputs: code_ready=0, dict_en=0, dict_addr=0, byte_valid=0, byte_data=0, byte_last=0.
REQ-033 Reset mid-EMIT discards pending bytes; none emitted after release; code_ready=1 first clock after release.

Structure
REQ-034 Package lzw_pkg SHALL hold CODE_W, CHAR_W, FIRST_DICT_CODE=256 and the FSM state type.
REQ-035 The LIFO SHALL be sub-module lzw_lifo (push, pop, flush, top, count, full); FSM stays in lzw_string_unwind.

Verification
REQ-036 Literal 0x41 accepted cycle 0 -> cycle 2 byte_valid, byte_data=0x41, byte_last=1, root_char=0x41.
REQ-037 Dict 256={prefix 0x41,char 0x42}, 257={256,0x43}; code 257 -> bytes 0x41,0x42,0x43, first at cycle 6, last on 0x43, dict_addr 257 then 256.
REQ-038 Code 257 with byte_ready toggling 1/0 each cycle -> same 3 bytes, data held stable while stalled, none dropped or duplicated.
REQ-039 STACK_DEPTH=4, chain length 6 (code 300->299->...->296->0x10) -> err_overflow=1, no byte_valid, code_ready=1, next literal 0x22 emitted correctly.
REQ-040 rst_n low after second byte of code 257 -> outputs zero; after release code_ready=1, no remaining bytes emitted.
REQ-041 code_valid held with literals 0x10 then 0x11 -> 0x11 accepted cycle after 0x10 popped; two single-byte strings, each byte_last=1.

Source files
------------

// File: rtl/lzw_pkg.sv
// Shared constants and FSM state type for the LZW string unwinder.
package lzw_pkg;

  localparam int CODE_W          = 13;
  localparam int CHAR_W          = 8;
  localparam int FIRST_DICT_CODE = 256;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WAIT,
    ROOT,
    EMIT
  } state_t;

endpackage

// File: rtl/lzw_lifo.sv
// Character LIFO used to reverse the prefix chain into first-to-last order.
module lzw_lifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        push_data,
  output logic [DATA_W-1:0]        top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       count_q;
  logic [AW:0]       top_idx;
  logic              do_push;

  assign do_push = push && !full && !flush;
  assign full    = (count_q == DEPTH_CNT);
  assign count   = count_q;
  assign top_idx = count_q - 1'b1;
  assign top     = mem[top_idx[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else if (do_push) begin
      count_q <= count_q + 1'b1;
    end else if (pop && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  // Storage carries no reset; only the occupancy count is control state.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[count_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/lzw_string_unwind.sv
// Expands an LZW code into its byte string by walking the prefix chain
// through an external dictionary and replaying the collected chars via a LIFO.
module lzw_string_unwind
  import lzw_pkg::*;
#(
  parameter int CODE_W      = lzw_pkg::CODE_W,
  parameter int CHAR_W      = lzw_pkg::CHAR_W,
  parameter int STACK_DEPTH = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code,
  output logic              code_ready,
  output logic              dict_en,
  output logic [CODE_W-1:0] dict_addr,
  input  logic [CODE_W-1:0] dict_prefix,
  input  logic [CHAR_W-1:0] dict_char,
  output logic              byte_valid,
  output logic [CHAR_W-1:0] byte_data,
  output logic              byte_last,
  input  logic              byte_ready,
  output logic [CHAR_W-1:0] root_char,
  output logic              err_overflow
);

  localparam int CNT_W = $clog2(STACK_DEPTH) + 1;
  localparam logic [CODE_W-1:0] FIRST_CODE = CODE_W'(FIRST_DICT_CODE);
  localparam logic [CNT_W-1:0]  ONE_ENTRY  = CNT_W'(1);

  state_t            state_q, state_d;
  logic [CODE_W-1:0] cur_q, cur_d;
  logic [CHAR_W-1:0] root_q;
  logic              err_q;

  logic              push, pop, flush, overflow, root_load;
  logic [CHAR_W-1:0] push_data, top;
  logic [CNT_W-1:0]  count;
  logic              full;

  lzw_lifo #(
    .DATA_W (CHAR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_lifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (push_data),
    .top       (top),
    .count     (count),
    .full      (full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      root_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      if (root_load) root_q <= cur_q[CHAR_W-1:0];
      if (overflow)  err_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    overflow   = 1'b0;
    root_load  = 1'b0;
    push_data  = dict_char;
    code_ready = 1'b0;
    dict_en    = 1'b0;
    dict_addr  = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    byte_last  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Held low while reset is asserted, since the state register already reads IDLE.
        code_ready = rst_n;
        if (code_valid && rst_n) begin
          cur_d   = code;
          state_d = (code < FIRST_CODE) ? ROOT : LOOKUP;
        end
      end
      LOOKUP: begin
        dict_en   = 1'b1;
        dict_addr = cur_q;
        state_d   = WAIT;
      end
      WAIT: begin
        if (full) begin
          flush    = 1'b1;
          overflow = 1'b1;
          state_d  = IDLE;
        end else begin
          push    = 1'b1;
          cur_d   = dict_prefix;
          state_d = (dict_prefix < FIRST_CODE) ? ROOT : LOOKUP;
        end
      end
      ROOT: begin
        push_data = cur_q[CHAR_W-1:0];
        if (full) begin
          flush    = 1'b1;
          overflow = 1'b1;
          state_d  = IDLE;
        end else begin
          push      = 1'b1;
          root_load = 1'b1;
          state_d   = EMIT;
        end
      end
      EMIT: begin
        byte_valid = 1'b1;
        byte_data  = top;
        byte_last  = (count == ONE_ENTRY);
        if (byte_ready) begin
          pop = 1'b1;
          if (count == ONE_ENTRY) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign root_char    = root_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_lzw_string_unwind.sv
// Bench for lzw_string_unwind: directed table, hand sequences and random codes vs a queue model.
`timescale 1ns/1ps
module tb_lzw_string_unwind;

  localparam int CODE_W = 13;
  localparam int CHAR_W = 8;
  localparam int DEPTH  = 4;

  typedef struct {
    int          code;
    int          mode;
    int          len;
    logic [31:0] bytes;
    int          addr2;
  } vec_t;

  logic              clk         = 1'b0;
  logic              rst_n       = 1'b0;
  logic              code_valid  = 1'b0;
  logic [CODE_W-1:0] code        = '0;
  logic              code_ready;
  logic              dict_en;
  logic [CODE_W-1:0] dict_addr;
  logic [CODE_W-1:0] dict_prefix = '0;
  logic [CHAR_W-1:0] dict_char   = '0;
  logic              byte_valid;
  logic [CHAR_W-1:0] byte_data;
  logic              byte_last;
  logic              byte_ready  = 1'b0;
  logic [CHAR_W-1:0] root_char;
  logic              err_overflow;

  int checks   = 0;
  int failures = 0;
  bit exp_err  = 1'b0;
  int exp_q[$];
  int addr_log[$];

  logic [CODE_W-1:0] mem_prefix [512];
  logic [CHAR_W-1:0] mem_char   [512];

  always #5 clk = ~clk;

  lzw_string_unwind #(
    .CODE_W      (CODE_W),
    .CHAR_W      (CHAR_W),
    .STACK_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .code_valid   (code_valid),
    .code         (code),
    .code_ready   (code_ready),
    .dict_en      (dict_en),
    .dict_addr    (dict_addr),
    .dict_prefix  (dict_prefix),
    .dict_char    (dict_char),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_last    (byte_last),
    .byte_ready   (byte_ready),
    .root_char    (root_char),
    .err_overflow (err_overflow)
  );

  // Registered dictionary: data appears the cycle after dict_en.
  always @(posedge clk) begin
    if (dict_en) begin
      dict_prefix <= mem_prefix[dict_addr[8:0]];
      dict_char   <= mem_char[dict_addr[8:0]];
      addr_log.push_back(int'(dict_addr));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: follow prefixes down to a literal, prepending each char.
  function automatic void model_expand(input int c);
    int x;
    x = c;
    exp_q = {};
    for (int guard = 0; guard < 64 && x >= 256; guard++) begin
      exp_q.push_front(int'(mem_char[x]));
      x = int'(mem_prefix[x]);
    end
    exp_q.push_front(x % 256);
  endfunction

  // mode 0: always ready, 1: ready toggles 0/1, 2: random ready
  task automatic run_code(input int c, input int mode, input string tag);
    int   n, first_cyc, len;
    bit   done, prev_stall, exp_ovf;
    logic [CHAR_W-1:0] prev_d;
    logic prev_l;
    int   got_d[$];
    int   got_l[$];
    len     = exp_q.size();
    exp_ovf = (len > DEPTH);
    addr_log = {};
    @(negedge clk);
    code       = CODE_W'(c);
    code_valid = 1'b1;
    n = 0;
    while (code_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (code_ready !== 1'b1) begin
      check({tag, " accept timeout"}, 32'd0, 32'd1);
      code_valid = 1'b0;
      return;
    end
    @(negedge clk);
    code_valid = 1'b0;
    code       = '0;
    n = 1; first_cyc = -1; done = 1'b0; prev_stall = 1'b0;
    prev_d = '0; prev_l = 1'b0;
    while (!done && n < 400) begin
      if (byte_valid === 1'b1) begin
        if (first_cyc < 0) first_cyc = n;
        if (prev_stall) begin
          check($sformatf("%s held data c%0d", tag, n), 32'(byte_data), 32'(prev_d));
          check($sformatf("%s held last c%0d", tag, n), 32'(byte_last), 32'(prev_l));
        end
        byte_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((n % 2) != 0) : ($urandom_range(0, 1) != 0);
        if (byte_ready) begin
          got_d.push_back(int'(byte_data));
          got_l.push_back(int'(byte_last));
          if (byte_last) done = 1'b1;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_d = byte_data;
          prev_l = byte_last;
        end
      end else begin
        if (prev_stall) check($sformatf("%s valid dropped c%0d", tag, n), 32'd0, 32'd1);
        prev_stall = 1'b0;
        byte_ready = (mode == 1) ? ((n % 2) != 0) : ($urandom_range(0, 1) != 0);
        if (exp_ovf && code_ready === 1'b1) done = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    byte_ready = 1'b0;
    if (!done) check({tag, " completion timeout"}, 32'd0, 32'd1);
    if (exp_ovf) begin
      exp_err = 1'b1;
      check({tag, " bytes on overflow"}, 32'(got_d.size()), 32'd0);
      check({tag, " code_ready after overflow"}, 32'(code_ready), 32'd1);
    end else begin
      check({tag, " byte count"}, 32'(got_d.size()), 32'(len));
      for (int i = 0; i < got_d.size() && i < len; i++) begin
        check($sformatf("%s byte%0d data", tag, i), 32'(got_d[i]), 32'(exp_q[i]));
        check($sformatf("%s byte%0d last", tag, i), 32'(got_l[i]), 32'(i == len - 1));
      end
      check({tag, " first byte cycle"}, 32'(first_cyc), 32'(2 * len));
      check({tag, " root_char"}, 32'(root_char), 32'(exp_q[0]));
      check({tag, " lookup count"}, 32'(addr_log.size()), 32'(len - 1));
      if (len > 1 && addr_log.size() > 0) check({tag, " first dict_addr"}, 32'(addr_log[0]), 32'(c));
    end
    check({tag, " err_overflow"}, 32'(err_overflow), 32'(exp_err));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " code_ready"},   32'(code_ready),   32'd0);
    check({tag, " dict_en"},      32'(dict_en),      32'd0);
    check({tag, " dict_addr"},    32'(dict_addr),    32'd0);
    check({tag, " byte_valid"},   32'(byte_valid),   32'd0);
    check({tag, " byte_data"},    32'(byte_data),    32'd0);
    check({tag, " byte_last"},    32'(byte_last),    32'd0);
    check({tag, " root_char"},    32'(root_char),    32'd0);
    check({tag, " err_overflow"}, 32'(err_overflow), 32'd0);
  endtask

  initial begin
    vec_t vecs[6];
    int   n, seen, vcount, c;
    for (int i = 0; i < 512; i++) begin
      mem_prefix[i] = '0;
      mem_char[i]   = '0;
    end
    mem_prefix[256] = 13'h041; mem_char[256] = 8'h42;
    mem_prefix[257] = 13'd256; mem_char[257] = 8'h43;
    for (int i = 258; i < 296; i++) begin
      if ($urandom_range(0, 2) == 0) mem_prefix[i] = CODE_W'($urandom_range(0, 255));
      else                           mem_prefix[i] = CODE_W'($urandom_range(256, i - 1));
      mem_char[i] = CHAR_W'($urandom_range(0, 255));
    end
    for (int i = 0; i < 5; i++) begin
      mem_prefix[296 + i] = (i == 0) ? 13'h010 : CODE_W'(295 + i);
      mem_char[296 + i]   = CHAR_W'(8'hA0 + i);
    end

    vecs[0] = '{32'h41,  0, 1, 32'h41,     -1};
    vecs[1] = '{257,     0, 3, 32'h414243, 256};
    vecs[2] = '{257,     1, 3, 32'h414243, 256};
    vecs[3] = '{256,     1, 2, 32'h4142,   -1};
    vecs[4] = '{32'hFF,  0, 1, 32'hFF,     -1};
    vecs[5] = '{0,       2, 1, 32'h00,     -1};

    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("code_ready after reset", 32'(code_ready), 32'd1);

    for (int v = 0; v < 6; v++) begin
      exp_q = {};
      for (int i = 0; i < vecs[v].len; i++)
        exp_q.push_back(int'((vecs[v].bytes >> (8 * (vecs[v].len - 1 - i))) & 32'hFF));
      run_code(vecs[v].code, vecs[v].mode, $sformatf("vec%0d", v));
      if (vecs[v].addr2 >= 0) begin
        if (addr_log.size() > 1) check($sformatf("vec%0d second dict_addr", v), 32'(addr_log[1]), 32'(vecs[v].addr2));
        else                     check($sformatf("vec%0d second lookup", v), 32'(addr_log.size()), 32'd2);
      end
    end

    // Back-to-back literals with code_valid held.
    @(negedge clk);
    code = 13'h010; code_valid = 1'b1; byte_ready = 1'b1;
    n = 0;
    while (code_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("b2b first accept", 32'(code_ready), 32'd1);
    @(negedge clk);
    code = 13'h011;
    check("b2b c1 code_ready", 32'(code_ready), 32'd0);
    @(negedge clk);
    check("b2b c2 byte_valid", 32'(byte_valid), 32'd1);
    check("b2b c2 byte_data",  32'(byte_data),  32'h10);
    check("b2b c2 byte_last",  32'(byte_last),  32'd1);
    check("b2b c2 code_ready", 32'(code_ready), 32'd0);
    @(negedge clk);
    check("b2b c3 code_ready", 32'(code_ready), 32'd1);
    @(negedge clk);
    code_valid = 1'b0;
    check("b2b c4 byte_valid", 32'(byte_valid), 32'd0);
    @(negedge clk);
    check("b2b c5 byte_valid", 32'(byte_valid), 32'd1);
    check("b2b c5 byte_data",  32'(byte_data),  32'h11);
    check("b2b c5 byte_last",  32'(byte_last),  32'd1);
    @(negedge clk);
    check("b2b c6 byte_valid", 32'(byte_valid), 32'd0);

    // Reset asserted after the second byte of code 257.
    code = 13'd257; code_valid = 1'b1; byte_ready = 1'b1;
    n = 0;
    while (code_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    code_valid = 1'b0;
    seen = 0; n = 0;
    while (seen < 2 && n < 50) begin
      if (byte_valid === 1'b1) seen++;
      if (seen < 2) begin @(negedge clk); n++; end
    end
    check("midreset bytes before reset", 32'(seen), 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset code_ready after release", 32'(code_ready), 32'd1);
    vcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (byte_valid === 1'b1) vcount++;
    end
    check("midreset stray bytes", 32'(vcount), 32'd0);
    byte_ready = 1'b0;

    for (int r = 0; r < 24; r++) begin
      c = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(256, 295));
      model_expand(c);
      run_code(c, 2, $sformatf("rand%0d code%0d", r, c));
    end

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_err = 1'b0;
    @(negedge clk);
    check("err cleared by reset", 32'(err_overflow), 32'd0);

    model_expand(300);
    check("overflow chain length", 32'(exp_q.size()), 32'd6);
    run_code(300, 0, "overflow300");
    exp_q = {};
    exp_q.push_back(32'h22);
    run_code(32'h22, 0, "post-overflow 0x22");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
